input_command_scheduler: RTL and testbench

INPUT_COMMAND_SCHEDULER -- requirements
Module: input_command_scheduler

---
 rtl/input_command_scheduler.sv | 143 ++++++++++++++
 tb/tb_input_command_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_command_scheduler.sv
`default_nettype none
// ============================================================================
// input_command_scheduler: key levels -> prioritised valid/ready command stream
// with left/right auto-repeat.                                        Rev 1.0
// ============================================================================
module input_command_scheduler #(
  parameter int DAS_CYCLES    = 20000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       left,
  input  logic       right,
  input  logic       enter,
  input  logic       enable,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       overrun
);

  localparam int MAX_CYCLES = (DAS_CYCLES > REPEAT_CYCLES) ? DAS_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             dir, dir_n;        // 0 = left, 1 = right (matches cmd_code)
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       rep;

  // Bit index equals cmd_code: 0 left, 1 right, 2 rotate, 3 enter.
  logic [3:0] keys, key_q, press, events, pend, pend_n, sel;
  logic [1:0] sel_code;
  logic       can_load, drop, held_track, held_other;

  assign keys       = {enter, up, right, left};
  assign press      = keys & ~key_q;
  assign held_track = dir ? right : left;
  assign held_other = dir ? left : right;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    dir_n   = dir;
    cnt_n   = cnt;
    rep     = 2'b00;
    case (state)
      IDLE: begin
        if (left ^ right) begin
          state_n = DELAY;
          dir_n   = right;
          cnt_n   = '0;
        end
      end
      DELAY, REPEAT: begin
        if (left && right) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!held_track) begin
          // Opposite key taking over on the same edge restarts the delay.
          state_n = held_other ? DELAY : IDLE;
          dir_n   = held_other ? ~dir : dir;
          cnt_n   = '0;
        end else if (cnt == ((state == DELAY) ? DAS_LAST : REP_LAST)) begin
          rep[dir] = 1'b1;
          state_n  = REPEAT;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      rep     = 2'b00;
    end
  end

  always_comb begin
    events   = enable ? (press | {2'b00, rep}) : 4'b0000;
    can_load = !cmd_valid || cmd_ready;
    sel      = 4'b0000;
    sel_code = 2'd0;
    if (enable && can_load) begin
      if (pend[3]) begin
        sel = 4'b1000; sel_code = 2'd3;
      end else if (pend[2]) begin
        sel = 4'b0100; sel_code = 2'd2;
      end else if (pend[0]) begin
        sel = 4'b0001; sel_code = 2'd0;
      end else if (pend[1]) begin
        sel = 4'b0010; sel_code = 2'd1;
      end
    end
    // A set on the load edge of the same command wins and is not a drop.
    drop   = |(events & pend & ~sel);
    pend_n = enable ? ((pend & ~sel) | events) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= 4'b0000;
      pend      <= 4'b0000;
      overrun   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code  <= 2'd0;
    end else begin
      key_q <= keys;
      pend  <= pend_n;
      if (drop) overrun <= 1'b1;
      if (can_load) begin
        cmd_valid <= |sel;
        if (|sel) cmd_code <= sel_code;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_command_scheduler.sv
`default_nettype none
// ============================================================================
// tb_input_command_scheduler: directed scenarios plus randomized run vs model.
//                                                                      Rev 1.0
// ============================================================================
module tb_input_command_scheduler;

  localparam int DAS = 8;
  localparam int REP = 4;

  logic       clk = 1'b0;
  logic       rst, up, left, right, enter, enable, cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       overrun;

  int vectors = 0;
  int errors  = 0;

  // Reference model state (indices follow command codes).
  bit m_kq[4];
  bit m_pend[4];
  bit m_valid, m_ovr, m_act;
  int m_code, m_dir, m_age;

  input_command_scheduler #(.DAS_CYCLES(DAS), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst), .up(up), .left(left), .right(right), .enter(enter),
    .enable(enable), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // One clock edge; the model advances with the inputs applied for that edge.
  task automatic step();
    bit k[4];
    bit ev[4];
    int order[4];
    int sel;
    order = '{3, 2, 0, 1};
    k[0] = left; k[1] = right; k[2] = up; k[3] = enter;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_kq[i] = 0; m_pend[i] = 0; end
      m_valid = 0; m_ovr = 0; m_act = 0; m_code = 0; m_dir = 0; m_age = 0;
    end else begin
      for (int i = 0; i < 4; i++) ev[i] = enable && k[i] && !m_kq[i];
      // Auto-repeat: fire at age DAS and every REP cycles after, while one key is held alone.
      if (!enable) m_act = 0;
      else if (m_act) begin
        if (left && right) m_act = 0;
        else if (!k[m_dir]) begin
          if (k[1-m_dir]) begin m_dir = 1 - m_dir; m_age = 0; end
          else m_act = 0;
        end else begin
          m_age++;
          if (m_age == DAS || (m_age > DAS && (m_age - DAS) % REP == 0)) ev[m_dir] = 1;
        end
      end else if (left != right) begin
        m_act = 1; m_dir = right ? 1 : 0; m_age = 0;
      end
      sel = -1;
      if (enable && (!m_valid || cmd_ready))
        for (int j = 0; j < 4; j++)
          if (sel < 0 && m_pend[order[j]]) sel = order[j];
      for (int i = 0; i < 4; i++)
        if (ev[i] && m_pend[i] && i != sel) m_ovr = 1;
      if (!m_valid || cmd_ready) begin
        if (sel >= 0) begin m_valid = 1; m_code = sel; end
        else m_valid = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (!enable) m_pend[i] = 0;
        else if (ev[i]) m_pend[i] = 1;
        else if (i == sel) m_pend[i] = 0;
        m_kq[i] = k[i];
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; up = 0; left = 0; right = 0; enter = 0; enable = 1; cmd_ready = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; up = 0; left = 0; right = 0; enter = 0; enable = 1; cmd_ready = 0;
    step(); step();
    vectors++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
    vectors++; if (cmd_code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", cmd_code); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 0;
  endtask

  task automatic test_tap_up();
    do_reset();
    up = 1;
    for (int n = 0; n < 5; n++) begin
      step();
      up = 0;
      vectors++;
      if (cmd_valid !== (n == 1)) begin errors++; $display("FAIL tap_valid edge %0d: got %b expected %b", n, cmd_valid, n == 1); end
      if (n == 1) begin
        vectors++; if (cmd_code !== 2'd2) begin errors++; $display("FAIL tap_code: got %0d expected 2", cmd_code); end
      end
    end
  endtask

  task automatic test_priority();
    int exp_code[4];
    bit exp_valid[4];
    exp_valid = '{0, 1, 1, 0};
    exp_code  = '{0, 3, 0, 0};
    do_reset();
    enter = 1; left = 1;
    for (int n = 0; n < 4; n++) begin
      step();
      enter = 0; left = 0;
      vectors++;
      if (cmd_valid !== exp_valid[n]) begin errors++; $display("FAIL prio_valid edge %0d: got %b expected %b", n, cmd_valid, exp_valid[n]); end
      if (exp_valid[n]) begin
        vectors++; if (cmd_code !== 2'(exp_code[n])) begin errors++; $display("FAIL prio_code edge %0d: got %0d expected %0d", n, cmd_code, exp_code[n]); end
      end
    end
  endtask

  task automatic test_hold_repeat();
    bit exp;
    do_reset();
    right = 1;
    for (int n = 0; n < 30; n++) begin
      step();
      exp = (n == 1) || (n >= DAS + 1 && (n - DAS - 1) % REP == 0);
      vectors++;
      if (cmd_valid !== exp) begin errors++; $display("FAIL hold_valid edge %0d: got %b expected %b", n, cmd_valid, exp); end
      if (exp) begin
        vectors++; if (cmd_code !== 2'd1) begin errors++; $display("FAIL hold_code edge %0d: got %0d expected 1", n, cmd_code); end
      end
    end
    right = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      vectors++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL hold_release edge %0d: got %b expected 0", n, cmd_valid); end
    end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL hold_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_backpressure();
    int xfers;
    do_reset();
    cmd_ready = 0; right = 1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (n >= 1) begin
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_code !== 2'd1) begin
          errors++; $display("FAIL bp_hold edge %0d: got valid %b code %0d expected valid 1 code 1", n, cmd_valid, cmd_code);
        end
      end
      vectors++;
      if (overrun !== (n >= DAS + REP)) begin errors++; $display("FAIL bp_overrun edge %0d: got %b expected %b", n, overrun, n >= DAS + REP); end
    end
    right = 0;
    step(); step();
    cmd_ready = 1; xfers = 0;
    for (int n = 0; n < 6; n++) begin
      if (cmd_valid && cmd_ready) xfers++;
      step();
    end
    vectors++; if (xfers != 2) begin errors++; $display("FAIL bp_transfers: got %0d expected 2", xfers); end
    vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_both_keys();
    bit exp;
    do_reset();
    left = 1;
    for (int n = 0; n < 24; n++) begin
      if (n == 5) right = 1;
      if (n == 10) left = 0;
      step();
      exp = (n == 1) || (n == 6) || (n == 19) || (n == 23);
      vectors++;
      if (cmd_valid !== exp) begin errors++; $display("FAIL both_valid edge %0d: got %b expected %b", n, cmd_valid, exp); end
      if (exp) begin
        vectors++;
        if (cmd_code !== ((n == 1) ? 2'd0 : 2'd1)) begin errors++; $display("FAIL both_code edge %0d: got %0d", n, cmd_code); end
      end
    end
    right = 0;
    step();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    cmd_ready = 0; right = 1;
    for (int n = 0; n < 14; n++) step();
    vectors++; if (overrun !== 1'b1 || cmd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got overrun %b valid %b expected 1 1", overrun, cmd_valid); end
    rst = 1;
    step();
    vectors++; if (cmd_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_rst: got valid %b overrun %b expected 0 0", cmd_valid, overrun); end
    rst = 0;
    step();
    vectors++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_first: got %b expected 0", cmd_valid); end
    step();
    vectors++; if (cmd_valid !== 1'b1 || cmd_code !== 2'd1) begin errors++; $display("FAIL mid_reissue: got valid %b code %0d expected 1 1", cmd_valid, cmd_code); end
    right = 0;
  endtask

  task automatic test_enable();
    do_reset();
    cmd_ready = 0; up = 1;
    step(); step();
    up = 0; enable = 0; enter = 1;
    step();
    vectors++; if (cmd_valid !== 1'b1 || cmd_code !== 2'd2) begin errors++; $display("FAIL en_keep: got valid %b code %0d expected 1 2", cmd_valid, cmd_code); end
    cmd_ready = 1;
    for (int n = 0; n < 3; n++) begin
      step();
      vectors++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL en_suppress %0d: got %b expected 0", n, cmd_valid); end
    end
    enable = 1;
    for (int n = 0; n < 3; n++) begin
      step();
      vectors++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL en_noevent %0d: got %b expected 0", n, cmd_valid); end
    end
    enter = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(11) == 0) left  = ~left;
      if ($urandom_range(13) == 0) right = ~right;
      if ($urandom_range(9)  == 0) up    = ~up;
      if ($urandom_range(15) == 0) enter = ~enter;
      cmd_ready = ($urandom_range(9) < 7);
      enable    = ($urandom_range(59) != 0);
      rst       = ($urandom_range(299) == 0);
      step();
      vectors++;
      if (cmd_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", n, cmd_valid, m_valid); end
      vectors++;
      if (cmd_code !== 2'(m_code)) begin errors++; $display("FAIL rnd_code cyc %0d: got %0d expected %0d", n, cmd_code, m_code); end
      vectors++;
      if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun cyc %0d: got %b expected %b", n, overrun, m_ovr); end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; up = 0; left = 0; right = 0; enter = 0; enable = 1; cmd_ready = 0;
    test_reset();
    test_tap_up();
    test_priority();
    test_hold_repeat();
    test_backpressure();
    test_both_keys();
    test_reset_midstream();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
